// File: rtl/vga_timing_cursor.sv
// Video timing generator with a box-and-crosshair cursor; every output is registered one pix_clk after the counters, no backpressure.
// Define VTG_BOUNCE_EN to ignore btn and let the cursor bounce between its clamp limits on its own.
module vga_timing_cursor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 12,
  parameter int COLOR_W  = 4,
  parameter int BOX_HALF = 16,
  parameter int LINE_W   = 4,
  parameter int ARM      = 10,
  parameter int STEP     = 2
) (
  input  logic                 pix_clk,
  input  logic                 pix_rst_n,
  input  logic [3:0]           btn,
  input  logic [3*COLOR_W-1:0] fg_rgb,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 vde,
  output logic [CW-1:0]        x,
  output logic [CW-1:0]        y,
  output logic                 frame_start,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);
  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC;
  localparam int RW  = 3 * COLOR_W;

  typedef logic signed [CW:0] pos_t;
  localparam pos_t CX_MIN = pos_t'(BOX_HALF);
  localparam pos_t CX_MAX = pos_t'(H_ACTIVE - 1 - BOX_HALF);
  localparam pos_t CY_MIN = pos_t'(BOX_HALF);
  localparam pos_t CY_MAX = pos_t'(V_ACTIVE - 1 - BOX_HALF);
  localparam pos_t CX_RST = pos_t'(H_ACTIVE / 2);
  localparam pos_t CY_RST = pos_t'(V_ACTIVE / 2);
  localparam pos_t STEP_P = pos_t'(STEP);
  localparam pos_t BH_P   = pos_t'(BOX_HALF);
  localparam pos_t EDGE_P = pos_t'(BOX_HALF - LINE_W);
  localparam pos_t ARM_P  = pos_t'(ARM);
  localparam pos_t ONE_P  = pos_t'(1);

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [3:0]    btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  pos_t          cx_q, cx_d, cy_q, cy_d, nx, ny;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d, fs_q, fs_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [RW-1:0] rgb_q, rgb_d;
  logic          h_last, v_last, at_origin;
  pos_t          ddx, ddy, dx, dy;
  logic          on_outline, on_cross;
`ifdef VTG_BOUNCE_EN
  logic          dirx_q, dirx_d, diry_q, diry_d;
`endif

  function automatic pos_t clamp(input pos_t v, input pos_t lo, input pos_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  always_comb begin
    h_last    = (hcnt_q == CW'(HT - 1));
    v_last    = (vcnt_q == CW'(VT - 1));
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    hcnt_d    = h_last ? '0 : hcnt_q + CW'(1);
    vcnt_d    = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
    btn_meta_d = btn;
    btn_sync_d = btn_meta_q;
  end

  // Cursor only moves on the (0,0) cycle, so a frame is always drawn with one position.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    nx   = cx_q;
    ny   = cy_q;
`ifdef VTG_BOUNCE_EN
    dirx_d = dirx_q;
    diry_d = diry_q;
    if (at_origin) begin
      nx = dirx_q ? cx_q - STEP_P : cx_q + STEP_P;
      ny = diry_q ? cy_q - STEP_P : cy_q + STEP_P;
      if (nx > CX_MAX) begin
        cx_d = CX_MAX; dirx_d = 1'b1;
      end else if (nx < CX_MIN) begin
        cx_d = CX_MIN; dirx_d = 1'b0;
      end else begin
        cx_d = nx;
      end
      if (ny > CY_MAX) begin
        cy_d = CY_MAX; diry_d = 1'b1;
      end else if (ny < CY_MIN) begin
        cy_d = CY_MIN; diry_d = 1'b0;
      end else begin
        cy_d = ny;
      end
    end
`else
    if (at_origin) begin
      if (btn_sync_q[0] && !btn_sync_q[1])      nx = cx_q + STEP_P;
      else if (btn_sync_q[1] && !btn_sync_q[0]) nx = cx_q - STEP_P;
      if (btn_sync_q[2] && !btn_sync_q[3])      ny = cy_q + STEP_P;
      else if (btn_sync_q[3] && !btn_sync_q[2]) ny = cy_q - STEP_P;
      cx_d = clamp(nx, CX_MIN, CX_MAX);
      cy_d = clamp(ny, CY_MIN, CY_MAX);
    end
`endif
  end

  always_comb begin
    ddx        = pos_t'({1'b0, hcnt_q}) - cx_q;
    ddy        = pos_t'({1'b0, vcnt_q}) - cy_q;
    dx         = ddx[CW] ? -ddx : ddx;
    dy         = ddy[CW] ? -ddy : ddy;
    on_outline = (dx <= BH_P) && (dy <= BH_P) && ((dx > EDGE_P) || (dy > EDGE_P));
    on_cross   = ((dx <= ARM_P) && (dy <= ONE_P)) || ((dy <= ARM_P) && (dx <= ONE_P));
    hsync_d    = ((hcnt_q >= CW'(HS0)) && (hcnt_q < CW'(HS1))) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((vcnt_q >= CW'(VS0)) && (vcnt_q < CW'(VS1))) ? SYNC_POL : ~SYNC_POL;
    vde_d      = (hcnt_q < CW'(H_ACTIVE)) && (vcnt_q < CW'(V_ACTIVE));
    x_d        = vde_d ? hcnt_q : '0;
    y_d        = vde_d ? vcnt_q : '0;
    fs_d       = at_origin;
    rgb_d      = '0;
    if (vde_d) rgb_d = (on_outline || on_cross) ? fg_rgb : bg_rgb;
  end

  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      cx_q       <= CX_RST;
      cy_q       <= CY_RST;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      vde_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      fs_q       <= 1'b0;
      rgb_q      <= '0;
`ifdef VTG_BOUNCE_EN
      dirx_q     <= 1'b0;
      diry_q     <= 1'b0;
`endif
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      vde_q      <= vde_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
`ifdef VTG_BOUNCE_EN
      dirx_q     <= dirx_d;
      diry_q     <= diry_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vde         = vde_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign red         = rgb_q[RW-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_cursor.sv
// Bench for vga_timing_cursor: scoreboarded per-pixel model on a reduced raster plus a small sync-polarity instance.
module tb_vga_timing_cursor;
  localparam int HA = 32, HF = 2, HS = 4, HB = 2;
  localparam int VA = 24, VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int BH = 6, LW = 2, ARM = 3, STEP = 2;
  localparam logic [39:0] RST1 = {1'b1, 1'b1, 1'b0, 12'h0, 12'h0, 1'b0, 12'h0};

  logic        pix_clk = 1'b0;
  logic        pix_rst_n = 1'b0;
  logic [3:0]  btn = 4'b0000;
  logic [11:0] fg_rgb = 12'hF00;
  logic [11:0] bg_rgb = 12'hFFF;
  logic        hsync, vsync, vde, frame_start;
  logic [11:0] x, y;
  logic [3:0]  red, green, blue;
  logic        hsync2, vsync2, vde2, frame_start2;
  logic [11:0] x2, y2;
  logic [3:0]  red2, green2, blue2;

  vga_timing_cursor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CW(12), .COLOR_W(4),
    .BOX_HALF(BH), .LINE_W(LW), .ARM(ARM), .STEP(STEP)
  ) u_dut (
    .pix_clk(pix_clk), .pix_rst_n(pix_rst_n), .btn(btn),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .hsync(hsync), .vsync(vsync), .vde(vde), .x(x), .y(y),
    .frame_start(frame_start), .red(red), .green(green), .blue(blue)
  );

  vga_timing_cursor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CW(12), .COLOR_W(4),
    .BOX_HALF(1), .LINE_W(1), .ARM(1), .STEP(1)
  ) u_dut2 (
    .pix_clk(pix_clk), .pix_rst_n(pix_rst_n), .btn(btn),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .hsync(hsync2), .vsync(vsync2), .vde(vde2), .x(x2), .y(y2),
    .frame_start(frame_start2), .red(red2), .green(green2), .blue(blue2)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct { int h; bit hs; bit de; } v2_t;
  typedef struct { int px; int py; bit de; logic [11:0] rgb; } probe_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_h = 0, m_v = 0, m_cx = HA / 2, m_cy = VA / 2;
  bit   m_dirx = 1'b0, m_diry = 1'b0;
  obs_t sb_q[$];
  obs_t sb_exp, sb_act;
  int   per = 0, de_cnt = 0;
  bit   fs_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic obs_t model_out(input int h, input int v, input int cx, input int cy,
                                     input logic [11:0] fg, input logic [11:0] bg);
    obs_t o;
    int   dx, dy;
    bit   hit;
    o.hs  = !(h >= HA + HF && h < HA + HF + HS);
    o.vs  = !(v >= VA + VF && v < VA + VF + VS);
    o.de  = (h < HA) && (v < VA);
    o.x   = o.de ? 12'(h) : 12'h0;
    o.y   = o.de ? 12'(v) : 12'h0;
    o.fs  = (h == 0) && (v == 0);
    dx    = (h > cx) ? h - cx : cx - h;
    dy    = (v > cy) ? v - cy : cy - v;
    hit   = ((dx <= BH && dy <= BH) && (dx > BH - LW || dy > BH - LW)) ||
            (dx <= ARM && dy <= 1) || (dy <= ARM && dx <= 1);
    o.rgb = !o.de ? 12'h0 : (hit ? fg : bg);
    return o;
  endfunction

  // Scoreboard: expectation for the current counter state is pushed, checked one cycle later.
  initial forever begin
    @(negedge pix_clk);
    if (!pix_rst_n) begin
      sb_q.delete();
      m_h = 0; m_v = 0; m_cx = HA / 2; m_cy = VA / 2; m_dirx = 1'b0; m_diry = 1'b0;
    end else begin
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        sb_act = {hsync, vsync, vde, x, y, frame_start, red, green, blue};
        chk("pixel", 64'(sb_act), 64'(sb_exp));
      end
      sb_q.push_back(model_out(m_h, m_v, m_cx, m_cy, fg_rgb, bg_rgb));
      if (m_h == 0 && m_v == 0) begin
`ifdef VTG_BOUNCE_EN
        m_cx = m_dirx ? m_cx - STEP : m_cx + STEP;
        m_cy = m_diry ? m_cy - STEP : m_cy + STEP;
        if (m_cx > HA - 1 - BH) begin m_cx = HA - 1 - BH; m_dirx = 1'b1; end
        else if (m_cx < BH)     begin m_cx = BH;          m_dirx = 1'b0; end
        if (m_cy > VA - 1 - BH) begin m_cy = VA - 1 - BH; m_diry = 1'b1; end
        else if (m_cy < BH)     begin m_cy = BH;          m_diry = 1'b0; end
`else
        if (btn[0] && !btn[1])      m_cx += STEP;
        else if (btn[1] && !btn[0]) m_cx -= STEP;
        if (btn[2] && !btn[3])      m_cy += STEP;
        else if (btn[3] && !btn[2]) m_cy -= STEP;
        m_cx = clampi(m_cx, BH, HA - 1 - BH);
        m_cy = clampi(m_cy, BH, VA - 1 - BH);
`endif
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
  end

  initial forever begin
    @(negedge pix_clk);
    if (!pix_rst_n) begin
      fs_seen = 1'b0; per = 0; de_cnt = 0;
    end else begin
      if (frame_start) begin
        if (fs_seen) begin
          chk("frame_period", 64'(per), 64'(HT * VT));
          chk("vde_per_frame", 64'(de_cnt), 64'(HA * VA));
        end
        fs_seen = 1'b1; per = 0; de_cnt = 0;
      end
      per++;
      if (vde) de_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge pix_clk); #2; end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    do begin
      @(posedge pix_clk); #2; n++;
    end while (!(m_h == h && m_v == v) && n < 3 * HT * VT);
    chk("wait_pos_timeout", 64'(n >= 3 * HT * VT), 64'(0));
  endtask

  initial begin
    v2_t    v2 [14];
    probe_t pr [9];
    int     k;
    logic   [27:0] exp2;
    v2 = '{'{0, 1'b0, 1'b1}, '{1, 1'b0, 1'b1}, '{2, 1'b0, 1'b1}, '{3, 1'b0, 1'b1},
           '{4, 1'b0, 1'b1}, '{5, 1'b0, 1'b1}, '{6, 1'b0, 1'b1}, '{7, 1'b0, 1'b1},
           '{8, 1'b0, 1'b0}, '{9, 1'b0, 1'b0}, '{10, 1'b1, 1'b0}, '{11, 1'b1, 1'b0},
           '{12, 1'b1, 1'b0}, '{13, 1'b0, 1'b0}};
    // Cursor at (16,12): box half 6, outline 2 wide, crosshair arm 3.
    pr = '{'{11, 7, 1'b1, 12'hF00}, '{13, 9, 1'b1, 12'hFFF}, '{19, 11, 1'b1, 12'hF00},
           '{16, 12, 1'b1, 12'hF00}, '{22, 12, 1'b1, 12'hF00}, '{23, 12, 1'b1, 12'hFFF},
           '{33, 12, 1'b0, 12'h000}, '{18, 15, 1'b1, 12'hFFF}, '{20, 16, 1'b1, 12'hFFF}};

    repeat (3) @(posedge pix_clk);
    #1;
    chk("reset_dut1", 64'({hsync, vsync, vde, x, y, frame_start, red, green, blue}), 64'(RST1));
    chk("reset_dut2", 64'({hsync2, vsync2, vde2, x2, y2, frame_start2, red2, green2, blue2}), 64'(0));
    @(posedge pix_clk); #2;
    pix_rst_n = 1'b1;

    k = 0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 14; i++) begin
        @(posedge pix_clk); #1; k++;
        exp2 = {v2[i].hs, 1'b0, v2[i].de, v2[i].de ? 12'(v2[i].h) : 12'h0,
                v2[i].de ? 12'(l) : 12'h0, (i == 0 && l == 0)};
        chk("dut2_line", 64'({hsync2, vsync2, vde2, x2, y2, frame_start2}), 64'(exp2));
      end
    end

    for (int i = 0; i < 9; i++) begin
      while (k < pr[i].py * HT + pr[i].px + 1) begin
        @(posedge pix_clk); k++;
      end
      #1;
      chk("pixel_probe", 64'({vde, x, y, red, green, blue}),
          64'({pr[i].de, pr[i].de ? 12'(pr[i].px) : 12'h0, pr[i].de ? 12'(pr[i].py) : 12'h0, pr[i].rgb}));
    end

    wait_pos(0, 15);
    btn = 4'b0001;
    repeat (9) wait_pos(0, 15);
    btn = 4'b0011;
    repeat (3) wait_pos(0, 15);
    btn = 4'b1000;
    repeat (5) wait_pos(0, 15);
    btn = 4'b0000;
    wait_pos(0, 15);
    btn = 4'b0100;
    tick(5);
    btn = 4'b0000;
    repeat (2) wait_pos(0, 15);
    btn = 4'b1100;
    fg_rgb = 12'h0A5;
    bg_rgb = 12'h123;
    repeat (2) wait_pos(0, 15);
    btn = 4'b0110;
    repeat (3) wait_pos(0, 15);
    btn = 4'b0000;

    wait_pos(30, 10);
    pix_rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({hsync, vsync, vde, x, y, frame_start, red, green, blue}), 64'(RST1));
    tick(3);
    chk("reset_hold", 64'({hsync, vsync, vde, x, y, frame_start, red, green, blue}), 64'(RST1));
    pix_rst_n = 1'b1;
    @(posedge pix_clk); #1;
    chk("fs_after_release", 64'({frame_start, frame_start2}), 64'(2'b11));
    repeat (2) wait_pos(0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
